clk_rst_seq: RTL and testbench

Clock/reset sequencer for the board top level. Runs on the free-running 100 MHz input clock and drives the DCM reset, waits for lock with timeout and retry, holds the GMII PHY in reset for a programmed interval, and only then releases the core reset. In RUN it monitors lock and CLKFX status and restarts the whole sequence on loss. `core_rst` feeds the existing `sync_reset` into the 125 MHz domain.

---
 rtl/clk_rst_seq.sv | 127 ++++++++++++
 tb/tb_clk_rst_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_rst_seq.sv
// Board-level clock/reset sequencer: DCM reset, lock wait with timeout/retry,
// timed PHY reset and settle, then core release with loss-of-lock supervision.
module clk_rst_seq #(
  parameter int DCM_RST_CYCLES  = 8,
  parameter int LOCK_TIMEOUT    = 100000,
  parameter int PHY_RST_CYCLES  = 1000000,
  parameter int PHY_WAIT_CYCLES = 500000,
  parameter int LOL_FILTER      = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       dcm_locked,
  input  logic       dcm_clkfx_stopped,
  input  logic       sw_rst_req,
  output logic       dcm_rst,
  output logic       phy_reset_n,
  output logic       core_rst,
  output logic       ready,
  output logic [2:0] state,
  output logic [7:0] retry_count,
  output logic [7:0] lol_count
);

  localparam int MAX_AB  = (DCM_RST_CYCLES > LOCK_TIMEOUT) ? DCM_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CD  = (PHY_RST_CYCLES > PHY_WAIT_CYCLES) ? PHY_RST_CYCLES : PHY_WAIT_CYCLES;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int FLT_W   = (LOL_FILTER > 1) ? $clog2(LOL_FILTER) : 1;

  typedef enum logic [2:0] {
    S_DCM_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_PHY_RST   = 3'd2,
    S_PHY_WAIT  = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  state_t           st, nxt;
  logic [CNT_W-1:0] cnt, cnt_load;
  logic [FLT_W-1:0] flt;
  logic             lk_m, lk_s, fs_m, fs_s;
  logic             expire, chk, lol_hit, fault, retry_inc;

  assign state = st;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    expire    = (cnt == '0);
    chk       = (st == S_PHY_RST) || (st == S_PHY_WAIT) || (st == S_RUN);
    lol_hit   = !lk_s && (flt == FLT_W'(LOL_FILTER - 1));
    fault     = chk && (fs_s || lol_hit);
    retry_inc = 1'b0;
    nxt       = st;

    if (fault) begin
      nxt = S_DCM_RST;
    end else if (sw_rst_req && (st != S_DCM_RST)) begin
      nxt = S_DCM_RST;
    end else begin
      case (st)
        S_DCM_RST:   if (expire) nxt = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          if (lk_s && !fs_s) begin
            nxt = S_PHY_RST;
          end else if (expire) begin
            nxt       = S_DCM_RST;
            retry_inc = 1'b1;
          end
        end
        S_PHY_RST:   if (expire) nxt = S_PHY_WAIT;
        S_PHY_WAIT:  if (expire) nxt = S_RUN;
        S_RUN:       nxt = S_RUN;
        default:     nxt = S_DCM_RST;
      endcase
    end

    // Entry loads N-1 and the state exits when the count reaches zero: N cycles.
    case (nxt)
      S_DCM_RST:   cnt_load = CNT_W'(DCM_RST_CYCLES - 1);
      S_WAIT_LOCK: cnt_load = CNT_W'(LOCK_TIMEOUT - 1);
      S_PHY_RST:   cnt_load = CNT_W'(PHY_RST_CYCLES - 1);
      S_PHY_WAIT:  cnt_load = CNT_W'(PHY_WAIT_CYCLES - 1);
      default:     cnt_load = '0;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lk_m        <= 1'b0;
      lk_s        <= 1'b0;
      fs_m        <= 1'b0;
      fs_s        <= 1'b0;
      st          <= S_DCM_RST;
      // The cycle before the first edge is not counted, hence the full N here.
      cnt         <= CNT_W'(DCM_RST_CYCLES);
      flt         <= '0;
      retry_count <= '0;
      lol_count   <= '0;
      dcm_rst     <= 1'b1;
      phy_reset_n <= 1'b0;
      core_rst    <= 1'b1;
      ready       <= 1'b0;
    end else begin
      lk_m <= dcm_locked;
      lk_s <= lk_m;
      fs_m <= dcm_clkfx_stopped;
      fs_s <= fs_m;
      st   <= nxt;

      if (nxt != st)        cnt <= cnt_load;
      else if (cnt != '0)   cnt <= cnt - CNT_W'(1);

      if ((nxt != st) || lk_s || !chk) flt <= '0;
      else                             flt <= flt + FLT_W'(1);

      if (retry_inc && (retry_count != 8'hFF)) retry_count <= retry_count + 8'd1;
      if (fault && (lol_count != 8'hFF))       lol_count   <= lol_count + 8'd1;

      dcm_rst     <= (nxt == S_DCM_RST);
      phy_reset_n <= (nxt == S_PHY_WAIT) || (nxt == S_RUN);
      core_rst    <= (nxt != S_RUN);
      ready       <= (nxt == S_RUN);
    end
  end

endmodule

// File: tb/tb_clk_rst_seq.sv
// Bench for clk_rst_seq: directed bring-up/fault scenarios plus randomized
// lock/CLKFX/request traffic, compared every cycle against a time-in-state model.
module tb_clk_rst_seq;

  localparam int T_DCM  = 4;
  localparam int T_LOCK = 20;
  localparam int T_PHY  = 10;
  localparam int T_WAIT = 6;
  localparam int T_LOL  = 3;
  localparam logic [22:0] RST_VEC = {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0};

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       dcm_locked = 1'b0;
  logic       dcm_clkfx_stopped = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       dcm_rst, phy_reset_n, core_rst, ready;
  logic [2:0] state;
  logic [7:0] retry_count, lol_count;

  clk_rst_seq #(
    .DCM_RST_CYCLES (T_DCM),
    .LOCK_TIMEOUT   (T_LOCK),
    .PHY_RST_CYCLES (T_PHY),
    .PHY_WAIT_CYCLES(T_WAIT),
    .LOL_FILTER     (T_LOL)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .dcm_locked       (dcm_locked),
    .dcm_clkfx_stopped(dcm_clkfx_stopped),
    .sw_rst_req       (sw_rst_req),
    .dcm_rst          (dcm_rst),
    .phy_reset_n      (phy_reset_n),
    .core_rst         (core_rst),
    .ready            (ready),
    .state            (state),
    .retry_count      (retry_count),
    .lol_count        (lol_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ecount   = 0;

  // Reference model: state index, edge of entry, edge counter, saturating counters,
  // and the recent history of sampled inputs (index 0 = this edge).
  int m_state, m_entry, m_k, m_retry, m_lol;
  bit lkq[$];
  bit fsq[$];

  int f, s, n, prev, last_rise, nrise, bad, burst;
  int t_dfall, t_phy, t_prel, t_rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_state = 0;
    m_entry = 1;   // the first edge after release starts DCM_RST cycle 1
    m_k     = 0;
    m_retry = 0;
    m_lol   = 0;
    lkq.delete();
    fsq.delete();
    for (int i = 0; i < 8; i++) begin
      lkq.push_back(1'b0);
      fsq.push_back(1'b0);
    end
  endfunction

  function automatic void model_step();
    int age, nxt;
    bit lk_sync, fs_sync, lost, chk, fault;
    m_k++;
    lkq.push_front(dcm_locked);
    void'(lkq.pop_back());
    fsq.push_front(dcm_clkfx_stopped);
    void'(fsq.pop_back());
    // Two synchronizer stages: decisions at this edge see the input of two edges ago.
    lk_sync = lkq[2];
    fs_sync = fsq[2];
    age  = m_k - m_entry;
    chk  = (m_state >= 2) && (m_state <= 4);
    lost = (age >= T_LOL);
    for (int j = 0; j < T_LOL; j++) if (lkq[2 + j]) lost = 1'b0;
    fault = chk && (fs_sync || lost);
    nxt = m_state;
    if (fault) begin
      nxt = 0;
      if (m_lol < 255) m_lol++;
    end else if (sw_rst_req && (m_state != 0)) begin
      nxt = 0;
    end else begin
      case (m_state)
        0: if (age == T_DCM) nxt = 1;
        1: begin
          if (lk_sync && !fs_sync) nxt = 2;
          else if (age == T_LOCK) begin
            nxt = 0;
            if (m_retry < 255) m_retry++;
          end
        end
        2: if (age == T_PHY) nxt = 3;
        3: if (age == T_WAIT) nxt = 4;
        default: ;
      endcase
    end
    if (nxt != m_state) begin
      m_state = nxt;
      m_entry = m_k;
    end
  endfunction

  function automatic logic [22:0] dut_vec();
    return {state, dcm_rst, phy_reset_n, core_rst, ready, retry_count, lol_count};
  endfunction

  function automatic logic [22:0] model_vec();
    return {3'(m_state), m_state == 0, m_state >= 3, m_state != 4, m_state == 4,
            8'(m_retry), 8'(m_lol)};
  endfunction

  task automatic tick();
    @(posedge clk);
    ecount++;
    model_step();
    #1;
    check("cycle", 32'(dut_vec()), 32'(model_vec()));
  endtask

  // Asserts reset between edges, checks the no-clock response, releases after one edge.
  task automatic do_reset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    check(tag, 32'(dut_vec()), 32'(RST_VEC));
    model_reset();
    ecount = 0;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] want, input int budget, input string tag);
    int k = 0;
    while ((state !== want) && (k < budget)) begin
      tick();
      k++;
    end
    check(tag, 32'(state), 32'(want));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset("reset_values");

    // Nominal bring-up, lock seen from cycle 8.
    t_dfall = -1; t_phy = -1; t_prel = -1; t_rdy = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ecount == 8) dcm_locked = 1'b1;
      if (t_dfall < 0 && !dcm_rst)            t_dfall = ecount;
      if (t_phy < 0 && state == 3'd2)         t_phy   = ecount;
      if (t_prel < 0 && phy_reset_n)          t_prel  = ecount;
      if (t_rdy < 0 && ready && !core_rst)    t_rdy   = ecount;
    end
    check("dcm_rst_fall_edge", t_dfall, 5);
    check("phy_rst_entry_edge", t_phy, 11);
    check("phy_release_edge", t_prel, 21);
    check("ready_edge", t_rdy, 27);
    check("nominal_retry", retry_count, 0);

    // Two-cycle lock glitch in RUN is filtered out.
    dcm_locked = 1'b0;
    repeat (2) tick();
    dcm_locked = 1'b1;
    repeat (6) tick();
    check("glitch_ready", ready, 1);
    check("glitch_lol", lol_count, 0);

    // Three-cycle lock loss in RUN restarts the sequence.
    f = ecount;
    dcm_locked = 1'b0;
    repeat (3) tick();
    dcm_locked = 1'b1;
    n = 0;
    while (ready && n < 10) begin tick(); n++; end
    check("lol_latency", ecount - f, 5);
    check("lol_dcm_rst", dcm_rst, 1);
    check("lol_count_1", lol_count, 1);

    // One-cycle CLKFX stop while in PHY_WAIT.
    wait_state(3'd3, 40, "reach_phy_wait");
    f = ecount;
    dcm_clkfx_stopped = 1'b1;
    tick();
    dcm_clkfx_stopped = 1'b0;
    n = 0;
    while (state != 3'd0 && n < 10) begin tick(); n++; end
    check("fs_latency", ecount - f, 3);
    check("fs_phy_reset_n", phy_reset_n, 0);
    check("fs_lol_count", lol_count, 2);

    // Software restart in RUN, then a request during DCM_RST that must be ignored.
    wait_state(3'd4, 40, "reach_run");
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    s = ecount;
    check("sw_enter_dcm_rst", state, 0);
    check("sw_lol_kept", lol_count, 2);
    check("sw_retry_kept", retry_count, 0);
    tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    n = 0;
    while (state == 3'd0 && n < 10) begin tick(); n++; end
    check("sw_ignored_dcm_len", ecount - s, T_DCM);
    n = 0;
    while (!ready && n < 40) begin tick(); n++; end
    check("replay_len", ecount - s, T_DCM + 1 + T_PHY + T_WAIT);

    // Async reset while in PHY_RST clears everything, counters included.
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    wait_state(3'd2, 20, "reach_phy_rst");
    repeat (2) tick();
    dcm_locked = 1'b0;
    do_reset("async_reset_phy_rst");

    // Lock never arrives: 4-cycle pulses every 24 cycles, retry saturates.
    prev = dcm_rst; last_rise = -1; nrise = 0; bad = 0;
    for (int i = 0; i < 7205; i++) begin
      tick();
      if (dcm_rst && !prev) begin
        if (nrise == 0 && ecount != 1 + T_DCM + T_LOCK) bad++;
        if (last_rise >= 0 && ecount - last_rise != T_DCM + T_LOCK) bad++;
        last_rise = ecount;
        nrise++;
      end
      if (!dcm_rst && prev && last_rise >= 0 && ecount - last_rise != T_DCM) bad++;
      prev = dcm_rst;
    end
    check("timeout_pulses", nrise, 300);
    check("timeout_shape", bad, 0);
    check("retry_saturated", retry_count, 255);

    // Randomized lock bursts, CLKFX pulses and restart requests.
    do_reset("random_start_reset");
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      if (burst > 0) begin
        dcm_locked = 1'b0;
        burst--;
      end else begin
        dcm_locked = 1'b1;
        if ($urandom_range(0, 99) < 4) burst = int'($urandom_range(1, 5));
      end
      dcm_clkfx_stopped = ($urandom_range(0, 99) < 2);
      sw_rst_req        = ($urandom_range(0, 149) == 0);
      tick();
      if (i == 1500) do_reset("random_mid_reset");
    end
    dcm_clkfx_stopped = 1'b0;
    sw_rst_req        = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
